// File: rtl/rtype_control_seq.sv
// Control-step sequencer for one three-register ALU instruction.
// Fetch is T0-T2 (with memory wait states in W1) and execute is T3-T5, with halt and illegal-register traps.
module rtype_control_seq #(
    parameter int unsigned     DATA_W      = 32,
    parameter int unsigned     NUM_REGS    = 16,
    parameter int unsigned     REG_FIELD_W = 4,
    parameter int unsigned     OP_W        = 5,
    parameter logic [OP_W-1:0] HALT_OP     = 5'b11011
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Run,
    input  logic                MemReady,
    input  logic [DATA_W-1:0]   IR,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                ZHighin,
    output logic                ZLowin,
    output logic                ZLowout,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [OP_W-1:0]     AluOp,
    output logic [3:0]          Step,
    output logic                Done,
    output logic                Halted,
    output logic                Error
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_W1   = 4'd3,
        S_T2   = 4'd4,
        S_T3   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam int unsigned RA_HI  = DATA_W - OP_W - 1;
    localparam int unsigned RB_HI  = RA_HI - REG_FIELD_W;
    localparam int unsigned RC_HI  = RB_HI - REG_FIELD_W;
    localparam int unsigned LOW_HI = RC_HI - REG_FIELD_W;

    state_t                 r_state;
    logic                   r_error;

    logic [OP_W-1:0]        w_op;
    logic [REG_FIELD_W-1:0] w_ra;
    logic [REG_FIELD_W-1:0] w_rb;
    logic [REG_FIELD_W-1:0] w_rc;
    logic                   w_halt;
    logic                   w_illegal;
    logic                   w_unused_ir;

    assign w_op        = IR[DATA_W-1 -: OP_W];
    assign w_ra        = IR[RA_HI -: REG_FIELD_W];
    assign w_rb        = IR[RB_HI -: REG_FIELD_W];
    assign w_rc        = IR[RC_HI -: REG_FIELD_W];
    assign w_unused_ir = ^IR[LOW_HI:0];

    assign w_halt    = (w_op == HALT_OP);
    assign w_illegal = (32'(w_ra) >= NUM_REGS) || (32'(w_rb) >= NUM_REGS)
                    || (32'(w_rc) >= NUM_REGS);

    // Out-of-range fields decode to all-zero, so Rin/Rout can never carry a stray bit.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_FIELD_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(idx) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state <= S_IDLE;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Run) begin
                        r_state <= S_T0;
                        r_error <= 1'b0;
                    end
                end
                S_T0: r_state <= S_T1;
                S_T1: r_state <= MemReady ? S_T2 : S_W1;
                S_W1: r_state <= MemReady ? S_T2 : S_W1;
                S_T2: r_state <= S_T3;
                S_T3: begin
                    if (w_halt) begin
                        r_state <= S_HALT;
                    end else if (w_illegal) begin
                        r_state <= S_IDLE;
                        r_error <= 1'b1;
                    end else begin
                        r_state <= S_T4;
                    end
                end
                S_T4:    r_state <= S_T5;
                S_T5:    r_state <= Run ? S_T0 : S_IDLE;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // IR is loaded by the datapath on the edge that leaves T2, so the execute steps
    // read the field selects live from IR rather than from a copy taken earlier.
    always_comb begin
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        ZHighin = 1'b0;
        ZLowin  = 1'b0;
        ZLowout = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Rin     = '0;
        Rout    = '0;
        AluOp   = '0;
        Done    = 1'b0;
        case (r_state)
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                ZLowin  = 1'b1;
                ZHighin = 1'b1;
            end
            S_T1: begin
                ZLowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_W1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (!w_halt && !w_illegal) begin
                    Rout = onehot(w_rb);
                    Yin  = 1'b1;
                end
            end
            S_T4: begin
                Rout    = onehot(w_rc);
                ZLowin  = 1'b1;
                ZHighin = 1'b1;
                AluOp   = w_op;
            end
            S_T5: begin
                ZLowout = 1'b1;
                Rin     = onehot(w_ra);
                Done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign Step   = r_state;
    assign Halted = (r_state == S_HALT);
    assign Error  = r_error;

endmodule

// File: tb/tb_rtype_control_seq.sv
// Directed bench for rtype_control_seq: a vector table for fetch/execute with wait states,
// plus sequences for back-to-back issue, halt, illegal register (NUM_REGS=8) and async Clear.
module tb_rtype_control_seq;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        Run;
    logic        MemReady;
    logic [31:0] IR;

    logic PCout, MARin, IncPC, ZHighin, ZLowin, ZLowout, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic [15:0] Rin, Rout;
    logic [4:0]  AluOp;
    logic [3:0]  Step;
    logic        Done, Halted, Error;

    logic PCout8, MARin8, IncPC8, ZHighin8, ZLowin8, ZLowout8, PCin8, Read8, MDRin8, MDRout8, IRin8, Yin8;
    logic [7:0]  Rin8, Rout8;
    logic [4:0]  AluOp8;
    logic [3:0]  Step8;
    logic        Done8, Halted8, Error8;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    rtype_control_seq #(.DATA_W(32), .NUM_REGS(16), .REG_FIELD_W(4), .OP_W(5), .HALT_OP(5'b11011)) dut16 (
        .Clock(Clock), .Clear(Clear), .Run(Run), .MemReady(MemReady), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .ZHighin(ZHighin), .ZLowin(ZLowin),
        .ZLowout(ZLowout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .Rin(Rin), .Rout(Rout), .AluOp(AluOp), .Step(Step),
        .Done(Done), .Halted(Halted), .Error(Error)
    );

    rtype_control_seq #(.DATA_W(32), .NUM_REGS(8), .REG_FIELD_W(4), .OP_W(5), .HALT_OP(5'b11011)) dut8 (
        .Clock(Clock), .Clear(Clear), .Run(Run), .MemReady(MemReady), .IR(IR),
        .PCout(PCout8), .MARin(MARin8), .IncPC(IncPC8), .ZHighin(ZHighin8), .ZLowin(ZLowin8),
        .ZLowout(ZLowout8), .PCin(PCin8), .Read(Read8), .MDRin(MDRin8), .MDRout(MDRout8),
        .IRin(IRin8), .Yin(Yin8), .Rin(Rin8), .Rout(Rout8), .AluOp(AluOp8), .Step(Step8),
        .Done(Done8), .Halted(Halted8), .Error(Error8)
    );

    logic [55:0] obs16;
    logic [39:0] obs8;
    assign obs16 = {Step, PCout, MARin, IncPC, ZHighin, ZLowin, ZLowout, PCin, Read, MDRin,
                    MDRout, IRin, Yin, Rin, Rout, AluOp, Done, Halted, Error};
    assign obs8  = {Step8, PCout8, MARin8, IncPC8, ZHighin8, ZLowin8, ZLowout8, PCin8, Read8,
                    MDRin8, MDRout8, IRin8, Yin8, Rin8, Rout8, AluOp8, Done8, Halted8, Error8};

    // Strobe order: PCout MARin IncPC ZHighin ZLowin ZLowout PCin Read MDRin MDRout IRin Yin
    localparam logic [11:0] ST0 = 12'b1111_1000_0000;
    localparam logic [11:0] ST1 = 12'b0000_0111_1000;
    localparam logic [11:0] SW1 = 12'b0000_0001_1000;
    localparam logic [11:0] ST2 = 12'b0000_0000_0110;
    localparam logic [11:0] ST3 = 12'b0000_0000_0001;
    localparam logic [11:0] ST4 = 12'b0001_1000_0000;
    localparam logic [11:0] ST5 = 12'b0000_0100_0000;
    localparam logic [11:0] SNO = 12'b0;

    typedef struct packed {
        logic        run;
        logic        mr;
        logic [3:0]  step;
        logic [11:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic        done;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic run, input logic mr, input logic [3:0] step,
                                input logic [11:0] strb, input logic [15:0] rin,
                                input logic [15:0] rout, input logic [4:0] alu, input logic done);
        vec_t v;
        v.run = run; v.mr = mr; v.step = step; v.strb = strb;
        v.rin = rin; v.rout = rout; v.alu = alu; v.done = done;
        return v;
    endfunction

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int          first_done;
    int          second_done;
    logic [3:0]  prev_step;
    logic        any8;

    initial begin
        // Plain instruction, then the same instruction with three W1 cycles (Run high but ignored mid-instruction).
        tbl[0]  = mk(1, 1, 4'd1, ST0, 16'h0, 16'h0, 5'd0, 0);
        tbl[1]  = mk(0, 1, 4'd2, ST1, 16'h0, 16'h0, 5'd0, 0);
        tbl[2]  = mk(0, 1, 4'd4, ST2, 16'h0, 16'h0, 5'd0, 0);
        tbl[3]  = mk(0, 1, 4'd5, ST3, 16'h0, 16'h4, 5'd0, 0);
        tbl[4]  = mk(0, 1, 4'd6, ST4, 16'h0, 16'h8, 5'd6, 0);
        tbl[5]  = mk(0, 1, 4'd7, ST5, 16'h2, 16'h0, 5'd0, 1);
        tbl[6]  = mk(0, 1, 4'd0, SNO, 16'h0, 16'h0, 5'd0, 0);
        tbl[7]  = mk(1, 1, 4'd1, ST0, 16'h0, 16'h0, 5'd0, 0);
        tbl[8]  = mk(0, 0, 4'd2, ST1, 16'h0, 16'h0, 5'd0, 0);
        tbl[9]  = mk(1, 0, 4'd3, SW1, 16'h0, 16'h0, 5'd0, 0);
        tbl[10] = mk(1, 0, 4'd3, SW1, 16'h0, 16'h0, 5'd0, 0);
        tbl[11] = mk(1, 0, 4'd3, SW1, 16'h0, 16'h0, 5'd0, 0);
        tbl[12] = mk(1, 1, 4'd4, ST2, 16'h0, 16'h0, 5'd0, 0);
        tbl[13] = mk(1, 1, 4'd5, ST3, 16'h0, 16'h4, 5'd0, 0);
        tbl[14] = mk(0, 1, 4'd6, ST4, 16'h0, 16'h8, 5'd6, 0);
        tbl[15] = mk(0, 1, 4'd7, ST5, 16'h2, 16'h0, 5'd0, 1);
        tbl[16] = mk(0, 1, 4'd0, SNO, 16'h0, 16'h0, 5'd0, 0);

        Clear = 1'b1; Run = 1'b1; MemReady = 1'b1; IR = 32'h30918000;
        tick;
        tick;
        check("reset16", 64'(obs16), 64'd0);
        check("reset8", 64'(obs8), 64'd0);
        Clear = 1'b0;

        for (int i = 0; i < 17; i++) begin
            Run = tbl[i].run;
            MemReady = tbl[i].mr;
            tick;
            check($sformatf("vec%0d", i), 64'(obs16),
                  64'({tbl[i].step, tbl[i].strb, tbl[i].rin, tbl[i].rout, tbl[i].alu,
                       tbl[i].done, 2'b00}));
        end

        // Back-to-back issue with Run held high.
        Clear = 1'b1; #1; Clear = 1'b0;
        Run = 1'b1; MemReady = 1'b1;
        first_done = -1; second_done = -1; prev_step = 4'd0;
        for (int c = 0; c < 14; c++) begin
            tick;
            if (prev_step == 4'd7) check($sformatf("b2b_7to1_c%0d", c), 64'(Step), 64'd1);
            prev_step = Step;
            if (Done) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        check("b2b_first_done", 64'(first_done), 64'd5);
        check("b2b_gap", 64'(second_done - first_done), 64'd6);

        // Halt opcode.
        Clear = 1'b1; #1; Clear = 1'b0;
        IR = 32'hD8000000; Run = 1'b1; MemReady = 1'b1;
        for (int c = 0; c < 4; c++) tick;
        check("halt_t3", 64'(obs16), 64'({4'd5, 52'd0}));
        tick;
        check("halt_state", 64'(obs16), 64'({4'd8, 49'd0, 1'b0, 1'b1, 1'b0}));
        for (int c = 0; c < 4; c++) begin
            Run = ~Run;
            MemReady = ~MemReady;
            tick;
        end
        check("halt_run_toggle", 64'(obs16), 64'({4'd8, 49'd0, 1'b0, 1'b1, 1'b0}));
        Clear = 1'b1; #1;
        check("halt_clear", 64'(obs16), 64'd0);

        // Illegal register field on the 8-register instance (ra = 9).
        IR = {5'b00110, 4'd9, 4'd2, 4'd3, 15'd0};
        tick;
        Clear = 1'b0; Run = 1'b1; MemReady = 1'b1;
        any8 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            Run = 1'b0;
            any8 = any8 | (|{Rin8, Rout8});
            if (c == 3) check("err_t3_step", 64'(Step8), 64'd5);
        end
        check("err_idle", 64'({Step8, Error8}), 64'({4'd0, 1'b1}));
        check("err_no_reg_sel", 64'(any8), 64'd0);
        tick;
        check("err_sticky", 64'({Step8, Error8}), 64'({4'd0, 1'b1}));
        Run = 1'b1;
        tick;
        check("err_clear_on_run", 64'({Step8, Error8}), 64'({4'd1, 1'b0}));

        // Asynchronous Clear between edges during T4.
        Clear = 1'b1; #1; Clear = 1'b0;
        IR = 32'h30918000; Run = 1'b1; MemReady = 1'b1;
        tick;
        Run = 1'b0;
        for (int c = 0; c < 4; c++) tick;
        check("t4_pre", 64'({Step, AluOp, Rout, ZLowin, ZHighin}),
              64'({4'd6, 5'd6, 16'h0008, 1'b1, 1'b1}));
        #3;
        Clear = 1'b1;
        #1;
        check("t4_async_clear", 64'({Step, AluOp, Rout, ZLowin, ZHighin}), 64'd0);
        Clear = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
